// File: rtl/pulp_clamp_pwr_ctrl_pkg.sv
// Package for the clamp/reset/power-switch sequencer of one switchable domain.
// Holds the FSM state encoding, the per-state output bundle and default timing
// constants shared by pulp_clamp_pwr_ctrl and its delay counter.
// Optional feature macro used by the top: PULP_CLAMP_PWR_CTRL_TIMEOUT_EN.

package pulp_clamp_pwr_ctrl_pkg;

    // Default timing constants (cycles of the always-on clock)
    localparam int unsigned PWR_SETTLE_CYCLES_DEF  = 8;
    localparam int unsigned PWR_CLAMP_SETUP_DEF    = 4;
    localparam int unsigned PWR_TIMEOUT_CYCLES_DEF = 256;

    // Sequencer states; order follows the power-up then power-down walk
    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_PWR_UP     = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_RST_REL    = 3'd3,
        ST_ON         = 3'd4,
        ST_CLAMP      = 3'd5,
        ST_RST_ASSERT = 3'd6,
        ST_PWR_DN     = 3'd7
    } pwr_state_e;

    // Registered output bundle (everything except the sticky timeout flag)
    typedef struct packed {
        logic switch_en;
        logic dom_rst_n;
        logic clamp;
        logic on_ack;
        logic off_ack;
        logic busy;
    } pwr_outs_t;

    // Output decode for a given state; the single source of the output table
    function automatic pwr_outs_t state_outs(input pwr_state_e s);
        pwr_outs_t o;
        o.switch_en = 1'b0;
        o.dom_rst_n = 1'b0;
        o.clamp     = 1'b1;
        o.on_ack    = 1'b0;
        o.off_ack   = 1'b0;
        o.busy      = 1'b1;
        case (s)
            ST_OFF: begin
                o.off_ack = 1'b1;
                o.busy    = 1'b0;
            end
            ST_PWR_UP,
            ST_SETTLE,
            ST_RST_ASSERT: begin
                o.switch_en = 1'b1;
            end
            ST_RST_REL,
            ST_CLAMP: begin
                o.switch_en = 1'b1;
                o.dom_rst_n = 1'b1;
            end
            ST_ON: begin
                o.switch_en = 1'b1;
                o.dom_rst_n = 1'b1;
                o.clamp     = 1'b0;
                o.on_ack    = 1'b1;
                o.busy      = 1'b0;
            end
            ST_PWR_DN: begin
                o.switch_en = 1'b0;
            end
            default: begin
                o.off_ack = 1'b1;
                o.busy    = 1'b0;
            end
        endcase
        return o;
    endfunction

    // Largest of three values, used to size the shared delay counter
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/pulp_pwr_delay_cnt.sv
// Shared delay counter for the power sequencer. Cleared to 0 on every state
// entry, counts while enabled and saturates once it reaches target_i, so a
// timed state lasts exactly target_i+1 cycles and the counter can never wrap.

module pulp_pwr_delay_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] target_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done_o = (cnt_q == target_i);

    // Next count: clear wins, otherwise step until the target is reached
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !done_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pulp_clamp_pwr_ctrl.sv
// Power-up/power-down sequencer for one switchable power domain, placed in the
// always-on domain. Orders clamp, domain reset and power switch so that the
// domain is clamped before reset and reset before power-off, and the reverse
// on power-up. All outputs come straight from flops.
// Optional feature: define PULP_CLAMP_PWR_CTRL_TIMEOUT_EN to bound the wait on
// switch_ack_i by TIMEOUT_CYCLES and raise a sticky timeout_err_o.

module pulp_clamp_pwr_ctrl
    import pulp_clamp_pwr_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = PWR_SETTLE_CYCLES_DEF,
    parameter int unsigned CLAMP_SETUP    = PWR_CLAMP_SETUP_DEF,
    parameter int unsigned TIMEOUT_CYCLES = PWR_TIMEOUT_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pwr_on_req_i,
    input  logic switch_ack_i,
    output logic switch_en_o,
    output logic dom_rst_no,
    output logic clamp_o,
    output logic pwr_on_ack_o,
    output logic pwr_off_ack_o,
    output logic busy_o,
    output logic timeout_err_o
);

    // Counter wide enough for the longest of the three delays
    localparam int unsigned CNT_W =
        $clog2(max3(SETTLE_CYCLES, CLAMP_SETUP, TIMEOUT_CYCLES)) + 1;

    // Counter compare values: a state of N cycles ends when the count hits N-1
    localparam logic [CNT_W-1:0] SETTLE_TGT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_TGT  = CNT_W'(CLAMP_SETUP - 1);
`ifdef PULP_CLAMP_PWR_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_TGT = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    pwr_state_e       state_q;
    pwr_state_e       state_d;
    pwr_outs_t        outs_q;

    logic             cnt_clear;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_target;
    logic             cnt_done;

`ifdef PULP_CLAMP_PWR_CTRL_TIMEOUT_EN
    logic             timeout_q;
    logic             timeout_d;
`endif

    // Restart the delay counter on every state change so each state starts at 0
    assign cnt_clear = (state_d != state_q);

    pulp_pwr_delay_cnt #(
        .CNT_W    (CNT_W)
    ) u_delay_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (cnt_clear),
        .en_i     (cnt_en),
        .target_i (cnt_target),
        .done_o   (cnt_done)
    );

    // Next-state logic: requests are only looked at in OFF and ON, so a request
    // that changes mid-sequence is picked up when the sequence settles there
    always_comb begin
        state_d    = state_q;
        cnt_en     = 1'b0;
        cnt_target = '0;
`ifdef PULP_CLAMP_PWR_CTRL_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_OFF: begin
`ifdef PULP_CLAMP_PWR_CTRL_TIMEOUT_EN
                if (pwr_on_req_i && !timeout_q) begin
                    state_d = ST_PWR_UP;
                end
`else
                if (pwr_on_req_i) begin
                    state_d = ST_PWR_UP;
                end
`endif
            end
            ST_PWR_UP: begin
`ifdef PULP_CLAMP_PWR_CTRL_TIMEOUT_EN
                cnt_en     = 1'b1;
                cnt_target = TIMEOUT_TGT;
                if (switch_ack_i) begin
                    state_d = ST_SETTLE;
                end else if (cnt_done) begin
                    state_d   = ST_OFF;
                    timeout_d = 1'b1;
                end
`else
                if (switch_ack_i) begin
                    state_d = ST_SETTLE;
                end
`endif
            end
            ST_SETTLE: begin
                cnt_en     = 1'b1;
                cnt_target = SETTLE_TGT;
                if (cnt_done) begin
                    state_d = ST_RST_REL;
                end
            end
            ST_RST_REL: begin
                cnt_en     = 1'b1;
                cnt_target = SETUP_TGT;
                if (cnt_done) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (!pwr_on_req_i) begin
                    state_d = ST_CLAMP;
                end
            end
            ST_CLAMP: begin
                cnt_en     = 1'b1;
                cnt_target = SETUP_TGT;
                if (cnt_done) begin
                    state_d = ST_RST_ASSERT;
                end
            end
            ST_RST_ASSERT: begin
                cnt_en     = 1'b1;
                cnt_target = SETUP_TGT;
                if (cnt_done) begin
                    state_d = ST_PWR_DN;
                end
            end
            ST_PWR_DN: begin
`ifdef PULP_CLAMP_PWR_CTRL_TIMEOUT_EN
                cnt_en     = 1'b1;
                cnt_target = TIMEOUT_TGT;
                if (!switch_ack_i) begin
                    state_d = ST_OFF;
                end else if (cnt_done) begin
                    state_d   = ST_OFF;
                    timeout_d = 1'b1;
                end
`else
                if (!switch_ack_i) begin
                    state_d = ST_OFF;
                end
`endif
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // State register; async reset drops straight back to OFF
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Output flops decoded from the next state so they change with the state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outs_q <= state_outs(ST_OFF);
        end else begin
            outs_q <= state_outs(state_d);
        end
    end

`ifdef PULP_CLAMP_PWR_CTRL_TIMEOUT_EN
    // Sticky timeout flag, only cleared by reset; it also locks the FSM in OFF
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err_o = timeout_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    assign switch_en_o   = outs_q.switch_en;
    assign dom_rst_no    = outs_q.dom_rst_n;
    assign clamp_o       = outs_q.clamp;
    assign pwr_on_ack_o  = outs_q.on_ack;
    assign pwr_off_ack_o = outs_q.off_ack;
    assign busy_o        = outs_q.busy;

endmodule

// File: tb/tb_pulp_clamp_pwr_ctrl.sv
// Scoreboard bench for pulp_clamp_pwr_ctrl with default parameters.
// Output vector order: {switch_en, dom_rst_n, clamp, on_ack, off_ack, busy, timeout}.
// With PULP_CLAMP_PWR_CTRL_TIMEOUT_EN defined the final scenario exercises the
// switch-ack timeout; otherwise it exercises an indefinite wait for the ack.

module tb_pulp_clamp_pwr_ctrl;

    localparam logic [6:0] O_OFF     = 7'b0010100;
    localparam logic [6:0] O_UP      = 7'b1010010;
    localparam logic [6:0] O_RST_REL = 7'b1110010;
    localparam logic [6:0] O_ON      = 7'b1101000;
    localparam logic [6:0] O_CLAMP   = 7'b1110010;
    localparam logic [6:0] O_RST_AS  = 7'b1010010;
    localparam logic [6:0] O_DN      = 7'b0010010;
    localparam logic [6:0] O_OFF_TO  = 7'b0010101;

    typedef struct {
        int         cyc;
        logic [6:0] outs;
        string      tag;
    } exp_t;

    logic clk;
    logic rst_n;
    logic req;
    logic ack;
    logic switchEn;
    logic domRstN;
    logic clamp;
    logic onAck;
    logic offAck;
    logic busy;
    logic timeoutErr;

    int         cyc = 0;
    int         nChecks = 0;
    int         nFails = 0;
    exp_t       expQ[$];
    logic [6:0] prevOuts = 7'bxxxxxxx;

    pulp_clamp_pwr_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pwr_on_req_i  (req),
        .switch_ack_i  (ack),
        .switch_en_o   (switchEn),
        .dom_rst_no    (domRstN),
        .clamp_o       (clamp),
        .pwr_on_ack_o  (onAck),
        .pwr_off_ack_o (offAck),
        .busy_o        (busy),
        .timeout_err_o (timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter: cycle n is the interval after rising edge n
    always @(posedge clk) cyc = cyc + 1;

    task automatic applyStimulus(input logic reqVal, input logic ackVal);
        req = reqVal;
        ack = ackVal;
    endtask

    task automatic pushExp(input int c, input logic [6:0] o, input string tag);
        exp_t e;
        e.cyc  = c;
        e.outs = o;
        e.tag  = tag;
        expQ.push_back(e);
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input exp_t e, input logic [6:0] cur);
        nChecks++;
        if (cur !== e.outs) begin
            nFails++;
            $display("[TB] FAIL %s outputs: got %b expected %b", e.tag, cur, e.outs);
        end
        if (e.cyc >= 0) begin
            nChecks++;
            if (cyc != e.cyc) begin
                nFails++;
                $display("[TB] FAIL %s cycle: got %0d expected %0d", e.tag, cyc, e.cyc);
            end
        end
    endtask

    // Monitor: every change of the output vector must match the next expected entry
    always @(negedge clk) begin
        logic [6:0] cur;
        exp_t       e;
        cur = {switchEn, domRstN, clamp, onAck, offAck, busy, timeoutErr};
        if (cur !== prevOuts) begin
            prevOuts = cur;
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected change: got %b at cycle %0d", cur, cyc);
            end else begin
                e = expQ.pop_front();
                checkOutput(e, cur);
            end
        end
    end

    initial begin
        int b;

        // Reset and idle in OFF with no request
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        pushExp(-1, O_OFF, "reset_off");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitUntil(cyc + 5);

        // Power-up, then an ack glitch while ON that must be ignored
        $display("[TB] power-up sequence");
        b = cyc;
        applyStimulus(1'b1, 1'b0);
        pushExp(b + 1,  O_UP,      "up_switch_en");
        pushExp(b + 11, O_RST_REL, "up_rst_release");
        pushExp(b + 15, O_ON,      "up_on");
        waitUntil(b + 2);
        applyStimulus(1'b1, 1'b1);
        waitUntil(b + 18);
        applyStimulus(1'b1, 1'b0);
        waitUntil(b + 21);
        applyStimulus(1'b1, 1'b1);
        waitUntil(b + 24);

        // Power-down from ON
        $display("[TB] power-down sequence");
        b = cyc;
        applyStimulus(1'b0, 1'b1);
        pushExp(b + 1,  O_CLAMP,  "dn_clamp");
        pushExp(b + 5,  O_RST_AS, "dn_rst_assert");
        pushExp(b + 9,  O_DN,     "dn_switch_off");
        pushExp(b + 12, O_OFF,    "dn_off");
        waitUntil(b + 11);
        applyStimulus(1'b0, 1'b0);
        waitUntil(b + 15);

        // Request pulses during SETTLE: reaches ON, then powers down on its own
        $display("[TB] request toggle mid-sequence");
        b = cyc;
        applyStimulus(1'b1, 1'b0);
        pushExp(b + 1,  O_UP,      "rt_switch_en");
        pushExp(b + 11, O_RST_REL, "rt_rst_release");
        pushExp(b + 15, O_ON,      "rt_on");
        pushExp(b + 16, O_CLAMP,   "rt_clamp");
        pushExp(b + 20, O_RST_AS,  "rt_rst_assert");
        pushExp(b + 24, O_DN,      "rt_switch_off");
        pushExp(b + 26, O_OFF,     "rt_off");
        waitUntil(b + 2);
        applyStimulus(1'b1, 1'b1);
        waitUntil(b + 5);
        applyStimulus(1'b0, 1'b1);
        waitUntil(b + 6);
        applyStimulus(1'b1, 1'b1);
        waitUntil(b + 7);
        applyStimulus(1'b0, 1'b1);
        waitUntil(b + 25);
        applyStimulus(1'b0, 1'b0);
        waitUntil(b + 30);

        // Asynchronous reset while in RST_REL
        $display("[TB] reset during reset release");
        b = cyc;
        applyStimulus(1'b1, 1'b0);
        pushExp(b + 1,  O_UP,      "ar_switch_en");
        pushExp(b + 11, O_RST_REL, "ar_rst_release");
        pushExp(b + 12, O_OFF,     "ar_async_off");
        waitUntil(b + 2);
        applyStimulus(1'b1, 1'b1);
        waitUntil(b + 12);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        waitUntil(b + 14);
        rst_n = 1'b1;
        waitUntil(b + 20);

`ifdef PULP_CLAMP_PWR_CTRL_TIMEOUT_EN
        // Ack never arrives: timeout, back to OFF and locked against requests
        $display("[TB] switch-ack timeout");
        b = cyc;
        applyStimulus(1'b1, 1'b0);
        pushExp(b + 1,   O_UP,     "to_switch_en");
        pushExp(b + 257, O_OFF_TO, "to_timeout_off");
        waitUntil(b + 270);
`else
        // Ack arrives very late: the sequencer just keeps waiting
        $display("[TB] long wait for switch ack");
        b = cyc;
        applyStimulus(1'b1, 1'b0);
        pushExp(b + 1,   O_UP,      "lw_switch_en");
        pushExp(b + 309, O_RST_REL, "lw_rst_release");
        pushExp(b + 313, O_ON,      "lw_on");
        waitUntil(b + 300);
        applyStimulus(1'b1, 1'b1);
        waitUntil(b + 316);
`endif

        // Every expected output change must have been seen
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL pending_expectations: got %0d left expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
